// File: rtl/wb_slave_regfile.sv
// rtl/wb_slave_regfile.sv - Wishbone classic slave register bank with byte enables, wait states and error termination
module wb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    we_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int                  NUM_LANES = DATA_WIDTH / 8;
    localparam int                  IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [NUM_LANES-1:0]    sel_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    // With no wait states the response is built in the same edge that accepts
    // the request, so the address/direction come straight from the bus.
    logic [ADDR_WIDTH-1:0]   req_adr;
    logic                    req_we;
    logic                    req_ok;
    logic [DATA_WIDTH-1:0]   req_rdata;

    assign req_adr   = (state == IDLE) ? adr_i : adr_q;
    assign req_we    = (state == IDLE) ? we_i  : we_q;
    assign req_ok    = {1'b0, req_adr} < REG_LIMIT;
    assign req_rdata = regs[req_adr[IDX_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= RESET_VALUE;
            end
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
            case (state)
                IDLE: begin
                    if (cyc_i && stb_i) begin
                        adr_q    <= adr_i;
                        dat_q    <= dat_i;
                        sel_q    <= sel_i;
                        we_q     <= we_i;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                        end else begin
                            state <= RESP;
                            ack_o <= req_ok;
                            err_o <= !req_ok;
                            dat_o <= (req_ok && !req_we) ? req_rdata : '0;
                        end
                    end
                end
                WAIT: begin
                    if (!cyc_i) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        state <= RESP;
                        ack_o <= req_ok;
                        err_o <= !req_ok;
                        dat_o <= (req_ok && !req_we) ? req_rdata : '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // ack_o is high here exactly when the latched address is in range
                    if (ack_o && we_q) begin
                        for (int b = 0; b < NUM_LANES; b++) begin
                            if (sel_q[b]) begin
                                regs[adr_q[IDX_W-1:0]][8*b +: 8] <= dat_q[8*b +: 8];
                            end
                        end
                    end
                    state <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// tb/tb_wb_slave_regfile.sv - scoreboard bench for wb_slave_regfile with zero and three wait states
module tb_wb_slave_regfile;

    localparam int          AW  = 8;
    localparam int          DW  = 32;
    localparam int          NR  = 16;
    localparam logic [31:0] RV1 = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [DW-1:0] rdat [2];
    logic [3:0]    sel  [2];
    logic          we   [2];
    logic          cyc  [2];
    logic          stb  [2];
    logic          ack  [2];
    logic          err  [2];

    wb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(rdat[0]),
        .sel_i(sel[0]), .we_i(we[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .ack_o(ack[0]), .err_o(err[0])
    );

    wb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3),
                       .RESET_VALUE(RV1)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(rdat[1]),
        .sel_i(sel[1]), .we_i(we[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .ack_o(ack[1]), .err_o(err[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        is_err;
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [2][NR];
    int          ws [2] = '{0, 3};

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            model[0][r] = 32'h0;
            model[1][r] = RV1;
        end
    endtask

    task automatic xfer(input int u, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s, input string tag);
        exp_t e;
        int   n;
        logic seen;
        e.is_err = (a >= NR);
        e.is_wr  = w;
        e.data   = (e.is_err || w) ? 32'h0 : model[u][a[3:0]];
        if (w && !e.is_err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[u][a[3:0]][8*b +: 8] = d[8*b +: 8];
            end
        end
        sb.push_back(e);
        @(negedge clk);
        adr[u] = a; wdat[u] = d; sel[u] = s; we[u] = w; cyc[u] = 1'b1; stb[u] = 1'b1;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[u] || err[u]) seen = 1'b1;
            else check({tag, " dat idle"}, rdat[u], 32'h0);
        end
        cyc[u] = 1'b0; stb[u] = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(ws[u] + 1));
        e = sb.pop_front();
        if (seen) begin
            check({tag, " ack"}, 32'(ack[u]), 32'(!e.is_err));
            check({tag, " err"}, 32'(err[u]), 32'(e.is_err));
            if (!e.is_wr || e.is_err) check({tag, " data"}, rdat[u], e.data);
        end
        @(negedge clk);
        check({tag, " pulse end"}, {30'h0, ack[u], err[u]}, 32'h0);
        check({tag, " dat after"}, rdat[u], 32'h0);
    endtask

    int resp;

    initial begin
        for (int u = 0; u < 2; u++) begin
            adr[u] = '0; wdat[u] = '0; sel[u] = '0; we[u] = 1'b0; cyc[u] = 1'b0; stb[u] = 1'b0;
        end
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset outputs", {rdat[u][29:0], ack[u], err[u]}, 32'h0);
        end
        rst = 1'b0;

        xfer(0, 1'b0, 8'h03, 32'h0, 4'hF, "t1 rd3");
        xfer(1, 1'b0, 8'h03, 32'h0, 4'hF, "t1 rv rd3");

        xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, "t2 wr5");
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, "t2 rd5");
        xfer(0, 1'b1, 8'h05, 32'h11223344, 4'h5, "t2 wr5 sel5");
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, "t2 rd5 merged");
        xfer(0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'h0, "t2 wr5 sel0");
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, "t2 rd5 sel0");

        xfer(1, 1'b1, 8'h02, 32'h5A5A0F0F, 4'hA, "t3 wr2");
        xfer(1, 1'b0, 8'h02, 32'h0, 4'hF, "t3 rd2");

        xfer(0, 1'b1, 8'h00, 32'h01020304, 4'hF, "t4 wr0");
        xfer(0, 1'b1, 8'h0F, 32'hF0F0F0F0, 4'hF, "t4 wr15");
        xfer(0, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, "t4 wr oor");
        xfer(0, 1'b0, 8'hFF, 32'h0, 4'hF, "t4 rd oor");
        xfer(1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, "t4 wr oor ws3");
        for (int r = 0; r < NR; r++) begin
            xfer(0, 1'b0, 8'(r), 32'h0, 4'hF, $sformatf("t4 rd%0d", r));
        end

        @(negedge clk);
        adr[1] = 8'h01; wdat[1] = 32'h12345678; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        resp = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[1] || err[1]) resp++;
        end
        check("t5 abort resp", 32'(resp), 32'h0);
        xfer(1, 1'b0, 8'h01, 32'h0, 4'hF, "t5 rd1");

        xfer(1, 1'b1, 8'h07, 32'hA5A5A5A5, 4'hF, "t6 wr7");
        xfer(1, 1'b0, 8'h07, 32'h0, 4'hF, "t6 rd7 pre");
        @(negedge clk);
        adr[1] = 8'h08; wdat[1] = 32'h87654321; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        adr[0] = 8'h0F; sel[0] = 4'hF; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk);
        #2;
        check("t6 ack before rst", 32'(ack[0]), 32'h1);
        rst = 1'b1;
        #1;
        check("t6 async ack", 32'(ack[0]), 32'h0);
        check("t6 async dat", rdat[0], 32'h0);
        check("t6 ws3 outputs", {rdat[1][29:0], ack[1], err[1]}, 32'h0);
        for (int u = 0; u < 2; u++) begin
            cyc[u] = 1'b0; stb[u] = 1'b0;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        resp = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0] || err[0] || ack[1] || err[1]) resp++;
        end
        check("t6 no resp", 32'(resp), 32'h0);
        xfer(1, 1'b0, 8'h07, 32'h0, 4'hF, "t6 rd7");
        xfer(1, 1'b0, 8'h08, 32'h0, 4'hF, "t6 rd8");
        xfer(0, 1'b0, 8'h05, 32'h0, 4'hF, "t6 rd5 ws0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_slave_regfile.md
Name: wb_slave_regfile

Overview:
- Parametrised Wishbone B4 classic-cycle slave: a bank of NUM_REGS registers of DATA_WIDTH bits each.
- Adds four things a single slave register does not have: per-byte write enables (sel_i), a programmable number of wait states, an error termination for out-of-range addresses, and abort on a dropped cycle.
- Sits behind the interconnect as a generic control/status register bank and is the drop-in successor of the single-register slave.

Parameters:
- ADDR_WIDTH, 8: width of adr_i; adr_i is a word index, not a byte address.
- DATA_WIDTH, 32: register and data bus width; must be a multiple of 8.
- NUM_REGS, 16: number of registers; 1..2**ADDR_WIDTH.
- WAIT_STATES, 0: extra cycles inserted between the request being accepted and ack_o/err_o; 0..15.
- RESET_VALUE, 0: value loaded into every register on reset.

Ports:
- clk_i, in, 1: clock; all logic is on the rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- adr_i, in, ADDR_WIDTH: register index.
- dat_i, in, DATA_WIDTH: write data.
- dat_o, out, DATA_WIDTH: read data.
- sel_i, in, DATA_WIDTH/8: byte-lane enables; bit n covers dat bits [8n+7:8n].
- we_i, in, 1: 1 = write, 0 = read.
- cyc_i, in, 1: bus cycle active.
- stb_i, in, 1: strobe.
- ack_o, out, 1: normal termination.
- err_o, out, 1: error termination (address out of range).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All registers = RESET_VALUE.
  - ack_o = 0, err_o = 0, dat_o = 0.
  - FSM returns to IDLE.
  - Any in-flight transaction is dropped with no write.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - On cyc_i & stb_i, latch adr_i, dat_i, sel_i, we_i.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
- WAIT:
  - Counter decrements once per cycle; go to RESP when it reaches 1.
  - If cyc_i drops: abort, go to IDLE, no write, no ack/err.
- RESP (exactly one cycle):
  - In-range (latched adr < NUM_REGS): ack_o = 1.
    - Read: dat_o = register[adr].
    - Write: at the clock edge ending RESP, each byte lane with sel = 1 is updated from the latched dat_i; lanes with sel = 0 are unchanged.
  - Out-of-range: err_o = 1, dat_o = 0, no register changes.
  - Next state is always TURN.
- TURN:
  - One idle cycle so the master can drop stb_i; ack_o = err_o = 0.
  - Then go to IDLE. A still-asserted stb_i is sampled again in IDLE as a new request.
- Latency: ack_o/err_o assert WAIT_STATES+1 cycles after the edge at which IDLE samples cyc_i & stb_i. Minimum back-to-back period is WAIT_STATES+3 cycles.
- Outputs:
  - ack_o and err_o are registered, never asserted together, and each lasts exactly one cycle.
  - dat_o is 0 whenever ack_o is low.
- A write with sel_i = 0 acknowledges normally and changes nothing.
- Inputs are latched at acceptance; changing adr_i, dat_i, sel_i or we_i during WAIT has no effect.
- cyc_i dropping in RESP does not cancel the write (commit happens at the RESP edge).
- Reset asserted mid-WAIT: the transaction is lost; the master sees no ack.

Test Plan:
1. Defaults DATA_WIDTH=32, NUM_REGS=16, WAIT_STATES=0. Read adr 0x03 after reset -> ack_o one cycle after strobe, dat_o = 0x00000000.
2. Write 0xDEADBEEF to adr 0x05 with sel=0xF, then read adr 0x05 -> 0xDEADBEEF. Write 0x11223344 with sel=0x5, then read -> 0xDE22BE44.
3. WAIT_STATES=3. Read adr 0x02 -> ack_o exactly 4 cycles after strobe sampled, high for 1 cycle; dat_o = 0 in all other cycles.
4. NUM_REGS=16. Write 0xCAFEF00D to adr 0x10 -> err_o = 1, ack_o = 0. Subsequent reads of adr 0x00..0x0F are unchanged.
5. WAIT_STATES=3. Start write 0x12345678 to adr 0x01, drop cyc_i after 1 wait cycle -> no ack/err; read adr 0x01 -> RESET_VALUE.
6. Write 0xA5A5A5A5 to adr 0x07, then assert rst_i for 1 cycle mid-WAIT of a following write to adr 0x08. Outputs go to 0 immediately; read adr 0x07 -> RESET_VALUE.
